// File: rtl/computation_layer_seq_pkg.sv
// Shared definitions for the computation_layer sequencer: field width and
// the sequencer state encodings (also used by the bench to decode state).
package computation_layer_seq_pkg;

   // Width of one field element carried on s_data / m_data / layer vectors.
   localparam int F_NBITS = 16;

   // Sequencer state encodings.
   localparam logic [1:0] ST_LOAD  = 2'd0;
   localparam logic [1:0] ST_START = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;
   localparam logic [1:0] ST_DRAIN = 2'd3;

   // The sequencer is idle (ready for a new frame) only in ST_LOAD.
   function automatic logic seq_is_busy(input logic [1:0] st);
      return st != ST_LOAD;
   endfunction

endpackage

// File: rtl/computation_layer_seq_unload.sv
// Output side of the sequencer: holds a snapshot of every gate output taken
// on the layer's ready pulse and streams it out one element per beat.
//
// Handshake: a beat transfers on a cycle where m_valid & m_ready are both
// high. While m_valid is high and m_ready is low, m_data and m_last do not
// change. m_valid never drops without a transfer of the last beat.
module computation_layer_seq_unload
   import computation_layer_seq_pkg::*;
#(
   parameter int ngates = 8
) (
   input  logic                           clk,
   input  logic                           rstb,
   input  logic                           capture,
   input  logic [ngates-1:0][F_NBITS-1:0] v_out,
   input  logic                           m_ready,
   output logic                           m_valid,
   output logic [F_NBITS-1:0]             m_data,
   output logic                           m_last,
   output logic                           last_taken
);

   localparam int ngbits = $clog2(ngates);

   // Index of the final beat; compared explicitly so odd sizes never wrap.
   localparam logic [ngbits-1:0] OUT_LAST = ngbits'(ngates - 1);

   logic [ngates-1:0][F_NBITS-1:0] obuf;
   logic [ngbits-1:0]              out_cnt;
   logic                           m_fire;
   logic                           at_last;

   assign m_fire  = m_valid & m_ready;
   assign at_last = (out_cnt == OUT_LAST);

   // Snapshot the layer outputs and walk the beat counter as beats are taken.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         obuf    <= '0;
         out_cnt <= '0;
         m_valid <= 1'b0;
      end else if (capture) begin
         obuf    <= v_out;
         out_cnt <= '0;
         m_valid <= 1'b1;
      end else if (m_fire) begin
         if (at_last) begin
            out_cnt <= '0;
            m_valid <= 1'b0;
         end else begin
            out_cnt <= out_cnt + 1'b1;
         end
      end
   end

   // Data and last flag come straight from registers, so they are stable
   // for as long as the beat is stalled.
   assign m_data     = obuf[out_cnt];
   assign m_last     = m_valid & at_last;
   assign last_taken = m_fire & at_last;

endmodule

// File: rtl/computation_layer_seq.sv
// Initiator side of the computation_layer en/ready handshake.
// Collects a frame of ninputs field elements from a serial stream, presents
// them in parallel to the layer, fires a single en pulse, waits for the
// layer's ready pulse, then streams the ngates results back out.
//
// Handshake: an input beat transfers on a cycle where s_valid & s_ready are
// both high; s_ready is high only while the sequencer is collecting a frame,
// so loading and draining never overlap.
module computation_layer_seq
   import computation_layer_seq_pkg::*;
#(
   parameter int ninputs  = 8,
   parameter int ngates   = 8,
   parameter int nmuxsels = 1
) (
   input  logic                            clk,
   input  logic                            rstb,
   input  logic                            s_valid,
   input  logic [F_NBITS-1:0]              s_data,
   output logic                            s_ready,
   input  logic [nmuxsels-1:0]             mux_sel_in,
   output logic                            layer_en,
   output logic [nmuxsels-1:0]             layer_mux_sel,
   output logic [ninputs-1:0][F_NBITS-1:0] layer_v_in,
   input  logic                            layer_ready_pulse,
   input  logic [ngates-1:0][F_NBITS-1:0]  layer_v_out,
   output logic                            m_valid,
   output logic [F_NBITS-1:0]              m_data,
   output logic                            m_last,
   input  logic                            m_ready,
   output logic                            busy
);

   // Derived widths live in the body so they cannot be overridden.
   localparam int ninbits = $clog2(ninputs);

   // Index of the final input beat; compared explicitly so odd sizes never wrap.
   localparam logic [ninbits-1:0] IN_LAST = ninbits'(ninputs - 1);

   logic [1:0]         state;
   logic [1:0]         state_nxt;
   logic [ninbits-1:0] in_cnt;
   logic               s_fire;
   logic               in_last;
   logic               capture;
   logic               drain_done;

   // All handshake-facing controls decode directly from the state register,
   // so they are glitch-free and change exactly on state transitions.
   assign s_ready  = (state == ST_LOAD);
   assign layer_en = (state == ST_START);
   assign busy     = seq_is_busy(state);

   assign s_fire  = s_valid & s_ready;
   assign in_last = (in_cnt == IN_LAST);

   // Only a pulse seen while waiting counts; a pulse during the start cycle
   // or earlier belongs to a previous operation and is dropped.
   assign capture = (state == ST_WAIT) & layer_ready_pulse;

   // Next-state decode for the load / start / wait / drain sequence.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_LOAD:  if (s_fire && in_last) state_nxt = ST_START;
         ST_START: state_nxt = ST_WAIT;
         ST_WAIT:  if (layer_ready_pulse) state_nxt = ST_DRAIN;
         ST_DRAIN: if (drain_done) state_nxt = ST_LOAD;
         default:  state_nxt = ST_LOAD;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state <= ST_LOAD;
      end else begin
         state <= state_nxt;
      end
   end

   // Input collection: each accepted beat lands in its slot; beat 0 also
   // carries the mux select. Nothing here changes outside ST_LOAD, which
   // keeps the layer inputs frozen from start until the drain completes.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         in_cnt        <= '0;
         layer_v_in    <= '0;
         layer_mux_sel <= '0;
      end else if (s_fire) begin
         layer_v_in[in_cnt] <= s_data;
         if (in_cnt == '0) begin
            layer_mux_sel <= mux_sel_in;
         end
         if (in_last) begin
            in_cnt <= '0;
         end else begin
            in_cnt <= in_cnt + 1'b1;
         end
      end
   end

   computation_layer_seq_unload #(
      .ngates (ngates)
   ) u_unload (
      .clk        (clk),
      .rstb       (rstb),
      .capture    (capture),
      .v_out      (layer_v_out),
      .m_ready    (m_ready),
      .m_valid    (m_valid),
      .m_data     (m_data),
      .m_last     (m_last),
      .last_taken (drain_done)
   );

endmodule

// File: tb/tb_computation_layer_seq.sv
// Bench for computation_layer_seq with a 4-input / 4-gate configuration and
// a behavioural add-gate layer stub.
module tb_computation_layer_seq;
   import computation_layer_seq_pkg::*;

   localparam int NIN  = 4;
   localparam int NG   = 4;
   localparam int NMS  = 1;
   localparam int W    = F_NBITS;
   localparam int MAXW = 100;

   typedef logic [W-1:0] word_t;

   // ---------------- clock / reset ----------------
   logic clk  = 1'b0;
   logic rstb = 1'b0;
   int   cyc  = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- DUT ----------------
   logic                     s_valid;
   word_t                    s_data;
   logic                     s_ready;
   logic [NMS-1:0]           mux_sel_in;
   logic                     layer_en;
   logic [NMS-1:0]           layer_mux_sel;
   logic [NIN-1:0][W-1:0]    layer_v_in;
   logic                     layer_ready_pulse;
   logic [NG-1:0][W-1:0]     layer_v_out;
   logic                     m_valid;
   word_t                    m_data;
   logic                     m_last;
   logic                     m_ready;
   logic                     busy;

   computation_layer_seq #(
      .ninputs  (NIN),
      .ngates   (NG),
      .nmuxsels (NMS)
   ) dut (
      .clk               (clk),
      .rstb              (rstb),
      .s_valid           (s_valid),
      .s_data            (s_data),
      .s_ready           (s_ready),
      .mux_sel_in        (mux_sel_in),
      .layer_en          (layer_en),
      .layer_mux_sel     (layer_mux_sel),
      .layer_v_in        (layer_v_in),
      .layer_ready_pulse (layer_ready_pulse),
      .layer_v_out       (layer_v_out),
      .m_valid           (m_valid),
      .m_data            (m_data),
      .m_last            (m_last),
      .m_ready           (m_ready),
      .busy              (busy)
   );

   // ---------------- layer stub ----------------
   // mux_sel 0: gate g = in[g] + in[g+1]; mux_sel 1: gate g = in[g+1] + in[g+2]
   // (indices mod 4). Outputs are garbage except in the ready-pulse cycle.
   int   lay_delay = 3;
   logic stale_en  = 1'b0;
   int   lay_cnt;
   logic model_pulse;
   int   pulse_cyc = 0;

   always @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         lay_cnt     <= 0;
         model_pulse <= 1'b0;
      end else begin
         model_pulse <= 1'b0;
         if (layer_en) begin
            lay_cnt <= lay_delay;
         end else if (lay_cnt != 0) begin
            lay_cnt <= lay_cnt - 1;
            if (lay_cnt == 1) model_pulse <= 1'b1;
         end
      end
   end

   always_comb begin
      layer_v_out = '0;
      for (int g = 0; g < NG; g++) begin
         if (!model_pulse) begin
            layer_v_out[g] = 16'hDEAD;
         end else if (layer_mux_sel == 1'b0) begin
            layer_v_out[g] = layer_v_in[g] + layer_v_in[(g + 1) % NIN];
         end else begin
            layer_v_out[g] = layer_v_in[(g + 1) % NIN] + layer_v_in[(g + 2) % NIN];
         end
      end
   end

   // A stale pulse coincides with the start cycle when stale_en is set.
   assign layer_ready_pulse = model_pulse | (stale_en & layer_en);

   always @(negedge clk) begin
      if (model_pulse) pulse_cyc = cyc;
   end

   // ---------------- scoreboard ----------------
   word_t exp_q[$];
   int    n_checks = 0;
   int    n_fail   = 0;
   int    beat_cyc;
   int    first_acc_cyc;
   int    last_acc_cyc;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [63:0] pack4(input word_t a, b, c, d);
      return {d, c, b, a};
   endfunction

   // ---------------- drivers ----------------
   // Returns at the negedge after the beat was accepted; beat_cyc holds the
   // cycle in which the transfer happened.
   task automatic send_beat(input word_t d, input logic ms);
      int t = 0;
      s_valid    = 1'b1;
      s_data     = d;
      mux_sel_in = ms;
      while (!s_ready && t < MAXW) begin
         @(negedge clk);
         t++;
      end
      chk("s_ready_wait", 64'(t < MAXW), 64'd1);
      chk("en_early", 64'(layer_en), 64'd0);
      beat_cyc = cyc;
      @(negedge clk);
      s_valid = 1'b0;
   endtask

   // Sends one frame; gap idle cycles between beats. mux_sel_in is inverted
   // on beats other than 0 so only beat 0's value may reach the layer.
   task automatic send_frame(input word_t v0, v1, v2, v3, input logic ms, input int gap);
      word_t v [NIN];
      v[0] = v0; v[1] = v1; v[2] = v2; v[3] = v3;
      for (int i = 0; i < NIN; i++) begin
         send_beat(v[i], (i == 0) ? ms : ~ms);
         if (i == 0) first_acc_cyc = beat_cyc;
         if (i < NIN - 1) repeat (gap) @(negedge clk);
      end
      // Cycle after the last beat: start pulse, inputs presented.
      chk("en_pulse", 64'(layer_en), 64'd1);
      chk("start_s_ready", 64'(s_ready), 64'd0);
      chk("start_busy", 64'(busy), 64'd1);
      chk("v_in", 64'(layer_v_in), pack4(v0, v1, v2, v3));
      chk("mux_sel", 64'(layer_mux_sel), 64'(ms));
      @(negedge clk);
      chk("en_single", 64'(layer_en), 64'd0);
      chk("wait_s_ready", 64'(s_ready), 64'd0);
   endtask

   // Receives nbeats from exp_q; stalls stall_len cycles on beat stall_at.
   task automatic receive_frame(input int nbeats, input int stall_at, input int stall_len,
                                input logic [63:0] exp_vin);
      int    t = 0;
      word_t e;
      word_t held;
      while (!m_valid && t < MAXW) begin
         @(negedge clk);
         t++;
      end
      chk("m_valid_wait", 64'(t < MAXW), 64'd1);
      chk("m_valid_latency", 64'(cyc), 64'(pulse_cyc + 1));
      for (int i = 0; i < nbeats; i++) begin
         e = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hFFFF;
         chk("m_valid", 64'(m_valid), 64'd1);
         chk("m_data", 64'(m_data), 64'(e));
         chk("m_last", 64'(m_last), 64'(i == NG - 1));
         chk("drain_s_ready", 64'(s_ready), 64'd0);
         chk("v_in_hold", 64'(layer_v_in), exp_vin);
         if (i == stall_at) begin
            m_ready = 1'b0;
            held    = m_data;
            repeat (stall_len) begin
               @(negedge clk);
               chk("stall_valid", 64'(m_valid), 64'd1);
               chk("stall_data", 64'(m_data), 64'(held));
               chk("stall_last", 64'(m_last), 64'(i == NG - 1));
            end
         end
         m_ready = 1'b1;
         if (i == NG - 1) last_acc_cyc = cyc;
         @(negedge clk);
      end
      m_ready = 1'b0;
      if (nbeats == NG) begin
         chk("done_m_valid", 64'(m_valid), 64'd0);
         chk("done_busy", 64'(busy), 64'd0);
         chk("done_s_ready", 64'(s_ready), 64'd1);
      end
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_s_ready"}, 64'(s_ready), 64'd1);
      chk({tag, "_m_valid"}, 64'(m_valid), 64'd0);
      chk({tag, "_m_last"}, 64'(m_last), 64'd0);
      chk({tag, "_layer_en"}, 64'(layer_en), 64'd0);
      chk({tag, "_busy"}, 64'(busy), 64'd0);
      chk({tag, "_v_in"}, 64'(layer_v_in), 64'd0);
      chk({tag, "_mux_sel"}, 64'(layer_mux_sel), 64'd0);
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #200000;
      $display("FAIL watchdog expired at t=%0t", $time);
      $fatal(1, "watchdog");
   end

   // ---------------- directed sequence ----------------
   initial begin
      s_valid    = 1'b0;
      s_data     = '0;
      mux_sel_in = '0;
      m_ready    = 1'b0;
      rstb       = 1'b0;
      repeat (3) @(negedge clk);
      rstb = 1'b1;
      @(negedge clk);
      check_reset_values("rst");

      // Add gates, contiguous input, stale pulse in the start cycle.
      stale_en = 1'b1;
      exp_q.push_back(16'd3); exp_q.push_back(16'd5);
      exp_q.push_back(16'd7); exp_q.push_back(16'd5);
      send_frame(16'd1, 16'd2, 16'd3, 16'd4, 1'b0, 0);
      receive_frame(NG, -1, 0, pack4(16'd1, 16'd2, 16'd3, 16'd4));
      stale_en = 1'b0;

      // Input gaps of two idle cycles, 5-cycle backpressure on beat 1.
      exp_q.push_back(16'd30); exp_q.push_back(16'd50);
      exp_q.push_back(16'd70); exp_q.push_back(16'd50);
      send_frame(16'd10, 16'd20, 16'd30, 16'd40, 1'b0, 2);
      receive_frame(NG, 1, 5, pack4(16'd10, 16'd20, 16'd30, 16'd40));

      // Back-to-back: frame B offered during frame A's drain, mux_sel 1.
      exp_q.push_back(16'd6);  exp_q.push_back(16'd10);
      exp_q.push_back(16'd14); exp_q.push_back(16'd10);
      exp_q.push_back(16'd13); exp_q.push_back(16'd15);
      exp_q.push_back(16'd13); exp_q.push_back(16'd11);
      send_frame(16'd2, 16'd4, 16'd6, 16'd8, 1'b0, 0);
      fork
         receive_frame(NG, 2, 3, pack4(16'd2, 16'd4, 16'd6, 16'd8));
         send_frame(16'd5, 16'd6, 16'd7, 16'd8, 1'b1, 0);
      join
      chk("b2b_no_overlap", 64'(first_acc_cyc), 64'(last_acc_cyc + 1));
      receive_frame(NG, -1, 0, pack4(16'd5, 16'd6, 16'd7, 16'd8));

      // Reset while waiting for the layer.
      lay_delay = 20;
      send_frame(16'd9, 16'd9, 16'd9, 16'd9, 1'b1, 0);
      repeat (3) @(negedge clk);
      chk("wait_busy", 64'(busy), 64'd1);
      rstb = 1'b0;
      #1;
      check_reset_values("rst_wait");
      @(negedge clk);
      rstb = 1'b1;
      lay_delay = 3;
      @(negedge clk);
      exp_q.push_back(16'd3); exp_q.push_back(16'd5);
      exp_q.push_back(16'd7); exp_q.push_back(16'd5);
      send_frame(16'd1, 16'd2, 16'd3, 16'd4, 1'b0, 0);
      receive_frame(NG, -1, 0, pack4(16'd1, 16'd2, 16'd3, 16'd4));

      // Reset part-way through the drain.
      exp_q.push_back(16'd2); exp_q.push_back(16'd3);
      send_frame(16'd1, 16'd1, 16'd2, 16'd2, 1'b0, 0);
      receive_frame(2, -1, 0, pack4(16'd1, 16'd1, 16'd2, 16'd2));
      chk("drain_busy", 64'(busy), 64'd1);
      rstb = 1'b0;
      #1;
      check_reset_values("rst_drain");
      @(negedge clk);
      rstb = 1'b1;
      @(negedge clk);
      exp_q.delete();
      exp_q.push_back(16'd1);   exp_q.push_back(16'd101);
      exp_q.push_back(16'd107); exp_q.push_back(16'd7);
      send_frame(16'd7, 16'd0, 16'd1, 16'd100, 1'b1, 1);
      receive_frame(NG, 3, 2, pack4(16'd7, 16'd0, 16'd1, 16'd100));

      chk("exp_q_empty", 64'(exp_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
